// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the 5-stage pipeline.
// Covers the hazards that bypassing cannot fix: load-use, fetch wait,
// data-memory wait, taken branch/jump redirect and halt. Also keeps
// saturating stall and flush counters for performance reporting.
// The current FSM state is exposed on fsm_state (RUN=0, DWAIT=1, HALT=2).
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             mem_branch_taken,
    input  logic             id_jump,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // An instruction fetch that finished while the data wait froze the
    // pipeline; remembered so the completion cycle does not refetch.
    logic ifetch_done;

    logic data_pend;
    logic load_use;
    logic wait_stall;
    logic data_done;
    logic flush_evt;

    assign fsm_state = state;

    // Hazard decode, next-state selection and the enable/flush outputs.
    always_comb begin
        state_next  = state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        flush_evt   = 1'b0;
        wait_stall  = 1'b0;
        data_done   = 1'b0;

        data_pend = mem_dREN | mem_dWEN;
        load_use  = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

        // Classify the data side first: it dominates every RUN hazard.
        case (state)
            DWAIT: begin
                if (dhit) data_done  = 1'b1;
                else      wait_stall = 1'b1;
            end
            RUN: begin
                if (data_pend) begin
                    if (dhit) data_done  = 1'b1;
                    else      wait_stall = 1'b1;
                end
            end
            default: ;
        endcase

        if (state == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (wait_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (data_done) begin
            // Whole pipeline advances once; IF/ID gets a bubble unless a
            // fetch completed now or during the wait.
            pc_en      = ihit | ifetch_done;
            ifid_flush = ~(ihit | ifetch_done);
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            // The redirect owns the PC even when the fetch has not returned.
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end

        if (wb_halt) begin
            state_next = HALT;
        end else if ((state == RUN) && wait_stall) begin
            state_next = DWAIT;
        end else if ((state == DWAIT) && data_done) begin
            state_next = RUN;
        end

        // While reset is held the outputs show the reset values directly.
        if (!nRST) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            flush_evt   = 1'b0;
        end
    end

    // State register, fetch-done memory and sticky halt flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            ifetch_done <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted | wb_halt;
            if (wait_stall) begin
                ifetch_done <= ifetch_done | ihit;
            end else if (data_done) begin
                ifetch_done <= 1'b0;
            end
        end
    end

    // Saturating performance counters; both freeze once halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state != HALT) && !pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a rule-level reference model.
// A second instance with 4-bit counters exercises saturation.
module tb_hazard_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_memread;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        mem_branch_taken, id_jump, wb_halt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  fsm_state;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic        ifid_flush4, idex_flush4, exmem_flush4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic [1:0]  fsm_state4;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    hazard_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .mem_branch_taken(mem_branch_taken), .id_jump(id_jump),
        .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .mem_branch_taken(mem_branch_taken), .id_jump(id_jump),
        .wb_halt(wb_halt), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .exmem_flush(exmem_flush4), .halted(halted4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .fsm_state(fsm_state4)
    );

    typedef struct packed {
        logic       ihit, dhit, dren, dwen, exmr;
        logic [4:0] ex_rt, id_rs, id_rt;
        logic       br, jmp, halt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;  // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush}
    } vec_t;

    vec_t tbl[14];

    // ---------------- reference model state ----------------
    bit          m_halt, m_wait, m_ifd;
    logic [31:0] m_stall, m_flush;
    logic [3:0]  m_stall4, m_flush4;

    function automatic in_t mk(logic ih, logic dh, logic dr, logic dw, logic em,
                               logic [4:0] er, logic [4:0] rs, logic [4:0] rt,
                               logic br, logic jp, logic ht);
        in_t v;
        v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.exmr = em;
        v.ex_rt = er; v.id_rs = rs; v.id_rt = rt;
        v.br = br; v.jmp = jp; v.halt = ht;
        return v;
    endfunction

    // Expected {flush_event, outputs} from the hazard rules.
    function automatic logic [8:0] model_out(in_t v);
        logic [7:0] o;
        logic       fe, pend, lu, fetched;
        o  = 8'b11111_000;
        fe = 1'b0;
        pend = m_wait || v.dren || v.dwen;
        lu = v.exmr && (v.ex_rt != 0) && (v.ex_rt == v.id_rs || v.ex_rt == v.id_rt);
        if (m_halt) begin
            o = 8'b00000_000;
        end else if (pend && !v.dhit) begin
            o = 8'b00000_000;
        end else if (pend) begin
            fetched = v.ihit || m_ifd;
            o = {fetched, 4'b1111, !fetched, 2'b00};
        end else if (v.br) begin
            o = 8'b11111_111; fe = 1'b1;
        end else if (lu) begin
            o = 8'b00111_010;
        end else if (v.jmp) begin
            o = 8'b11111_100; fe = 1'b1;
        end else if (!v.ihit) begin
            o = 8'b01111_100;
        end
        return {fe, o};
    endfunction

    task automatic model_reset();
        m_halt = 0; m_wait = 0; m_ifd = 0;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(in_t v);
        ihit = v.ihit; dhit = v.dhit; mem_dREN = v.dren; mem_dWEN = v.dwen;
        ex_memread = v.exmr; ex_rt = v.ex_rt; id_rs = v.id_rs; id_rt = v.id_rt;
        mem_branch_taken = v.br; id_jump = v.jmp; wb_halt = v.halt;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic cycle(in_t v, output logic [7:0] got);
        logic [8:0] mo;
        logic [7:0] p4;
        logic       pend, stl, done;
        apply(v);
        @(negedge CLK);
        mo  = model_out(v);
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush};
        p4  = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
               ifid_flush4, idex_flush4, exmem_flush4};
        chk("outputs", {24'd0, got}, {24'd0, mo[7:0]});
        chk("outputs_w4", {24'd0, p4}, {24'd0, mo[7:0]});
        chk("flush_needs_en",
            {29'd0, got[2] & ~got[6], got[1] & ~got[5], got[0] & ~got[4]}, 32'd0);
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("state", {30'd0, fsm_state}, m_halt ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, m_stall4});
        chk("flush_cnt4", {28'd0, flush_cnt4}, {28'd0, m_flush4});
        @(posedge CLK);
        pend = m_wait || v.dren || v.dwen;
        stl  = !m_halt && pend && !v.dhit;
        done = !m_halt && pend && v.dhit;
        if (!m_halt && !mo[7]) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1;
        end
        if (mo[8]) begin
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            if (m_flush4 != 4'hF) m_flush4 = m_flush4 + 1;
        end
        if (stl && v.ihit) m_ifd = 1;
        if (done) m_ifd = 0;
        if (v.halt) m_halt = 1;
        else if (stl) m_wait = 1;
        else if (done) m_wait = 0;
        #1;
    endtask

    // Asynchronous reset pulse between clock edges, checked without an edge.
    task automatic do_reset();
        nRST = 1'b0;
        #1;
        chk("rst_outputs", {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                            ifid_flush, idex_flush, exmem_flush}, 32'h0000_00F8);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
        chk("rst_counters", stall_cnt | flush_cnt, 32'd0);
        model_reset();
        nRST = 1'b1;
        #1;
    endtask

    initial begin : main
        logic [7:0]  got;
        logic [31:0] s0;
        in_t         v;

        tbl[0]  = '{mk(1,0,0,0,0, 0,0,0, 0,0,0), 8'b11111_000};
        tbl[1]  = '{mk(0,0,0,0,0, 0,0,0, 0,0,0), 8'b01111_100};
        tbl[2]  = '{mk(1,0,0,0,1, 8,8,0, 0,0,0), 8'b00111_010};
        tbl[3]  = '{mk(0,0,0,0,1, 8,3,8, 0,0,0), 8'b00111_010};
        tbl[4]  = '{mk(1,0,0,0,1, 0,0,0, 0,0,0), 8'b11111_000};
        tbl[5]  = '{mk(1,0,0,0,1, 8,8,0, 1,0,0), 8'b11111_111};
        tbl[6]  = '{mk(1,0,0,0,0, 0,0,0, 0,1,0), 8'b11111_100};
        tbl[7]  = '{mk(0,0,0,0,0, 0,0,0, 0,1,0), 8'b11111_100};
        tbl[8]  = '{mk(1,0,0,0,1, 5,0,5, 0,1,0), 8'b00111_010};
        tbl[9]  = '{mk(1,0,0,0,1, 8,9,10, 0,0,0), 8'b11111_000};
        tbl[10] = '{mk(0,0,0,0,0, 0,0,0, 1,0,0), 8'b11111_111};
        tbl[11] = '{mk(1,1,0,1,0, 0,0,0, 0,0,0), 8'b11111_000};
        tbl[12] = '{mk(0,1,0,1,0, 0,0,0, 0,0,0), 8'b01111_100};
        tbl[13] = '{mk(0,1,1,0,0, 0,0,0, 1,0,0), 8'b01111_100};

        nRST = 1'b0;
        apply(mk(0,0,0,0,0, 0,0,0, 0,0,0));
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();

        // Directed single-cycle vectors from RUN.
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].in, got);
            chk($sformatf("vec%0d", i), {24'd0, got}, {24'd0, tbl[i].exp});
        end

        // Load-use bubble then free advance; ex_rt=0 never stalls.
        do_reset();
        cycle(mk(1,0,0,0,1, 8,8,0, 0,0,0), got);
        cycle(mk(1,0,0,0,0, 0,0,0, 0,0,0), got);
        chk("lu_next_adv", {24'd0, got}, 32'h0000_00F8);
        cycle(mk(1,0,0,0,1, 0,0,0, 0,0,0), got);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // Data wait with a fetch completing mid-wait.
        do_reset();
        s0 = m_stall;
        cycle(mk(0,0,1,0,0, 0,0,0, 0,0,0), got);
        cycle(mk(1,0,1,0,0, 0,0,0, 0,0,0), got);
        cycle(mk(0,0,1,0,0, 0,0,0, 0,0,0), got);
        chk("dwait_state", {30'd0, fsm_state}, 32'd1);
        cycle(mk(0,1,1,0,0, 0,0,0, 0,0,0), got);
        chk("dwait_done", {24'd0, got}, 32'h0000_00F8);
        chk("dwait_stall3", stall_cnt, s0 + 32'd3);

        // Branch beats a concurrent load-use.
        do_reset();
        cycle(mk(1,0,0,0,1, 8,8,0, 1,0,0), got);
        chk("br_over_lu", {24'd0, got}, 32'h0000_00FF);
        chk("br_flush_cnt", flush_cnt, 32'd1);

        // Halt during a data wait, then reset discards the pending fetch.
        do_reset();
        cycle(mk(0,0,0,1,0, 0,0,0, 0,0,0), got);
        cycle(mk(1,0,0,1,0, 0,0,0, 0,0,0), got);
        cycle(mk(0,0,0,1,0, 0,0,0, 0,0,1), got);
        chk("halt_rises", {31'd0, halted}, 32'd1);
        s0 = m_stall;
        cycle(mk(1,1,0,1,0, 0,0,0, 0,0,0), got);
        cycle(mk(1,1,0,0,0, 0,0,0, 1,0,0), got);
        chk("halt_en_zero", {24'd0, got}, 32'd0);
        chk("halt_frozen", stall_cnt, s0);
        do_reset();
        cycle(mk(0,1,0,1,0, 0,0,0, 0,0,0), got);
        chk("ifd_discard", {24'd0, got}, 32'h0000_007C);

        // Saturation of the 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(mk(0,0,0,0,0, 0,0,0, 0,0,0), got);
        chk("sat4_stall", {28'd0, stall_cnt4}, 32'd15);
        chk("stall32_20", stall_cnt, 32'd20);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
                   $urandom_range(0, 59) == 0);
            cycle(v, got);
            if ((m_halt && $urandom_range(0, 3) == 0) ||
                (m_wait && $urandom_range(0, 9) == 0)) begin
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
